// File: rtl/serial_adder_mealy_pkg.sv
// Shared definitions for the bit-serial Mealy adder: carry-state encoding
// and a helper that maps a raw carry bit onto that encoding.
package serial_adder_mealy_pkg;

    typedef enum logic {
        CARRY0 = 1'b0,
        CARRY1 = 1'b1
    } carry_state_e;

    function automatic carry_state_e carry_to_state(input logic carry_bit);
        if (carry_bit == 1'b1) begin
            return CARRY1;
        end else begin
            return CARRY0;
        end
    endfunction

endpackage

// File: rtl/serial_adder_mealy_full_adder.sv
// One-bit full adder: sum and carry-out for the current serial bit position.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the three-input parity; carry-out is the three-input majority.
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder_mealy.sv
// Bit-serial adder, LSB first. A single flip-flop holds the carry between bit
// positions; the sum bit is combinational from the present operands and carry.
module serial_adder_mealy
    import serial_adder_mealy_pkg::*;
#(
    parameter logic CARRY_INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic y,
    output logic q
);

    localparam carry_state_e INIT_STATE = carry_to_state(CARRY_INIT);

    carry_state_e state_q;
    carry_state_e state_d;
    logic         sum_s;
    logic         cout_s;

    full_adder u_full_adder (
        .a    (a),
        .b    (b),
        .cin  (state_q),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Next-state: set only on a=b=1, clear only on a=b=0, else hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CARRY0: begin
                if (cout_s == 1'b1) begin
                    state_d = CARRY1;
                end else begin
                    state_d = CARRY0;
                end
            end
            CARRY1: begin
                if (cout_s == 1'b0) begin
                    state_d = CARRY0;
                end else begin
                    state_d = CARRY1;
                end
            end
            default: begin
                state_d = INIT_STATE;
            end
        endcase
    end

    // Carry register; synchronous reset takes priority over any operand values.
    always_ff @(posedge clk) begin
        if (reset == 1'b0) begin
            state_q <= INIT_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sum follows operands with zero latency; carry is exposed straight from the flop.
    always_comb begin
        y = sum_s;
        q = state_q;
    end

endmodule

// File: tb/tb_serial_adder_mealy.sv
// Directed self-checking bench for serial_adder_mealy with hand-computed vectors.
module tb_serial_adder_mealy;

    logic clk;
    logic reset;
    logic a;
    logic b;
    logic y;
    logic q;

    int errors;
    int checks;

    serial_adder_mealy #(.CARRY_INIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; a = 1'b1; b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q !== 1'b0) begin errors++; $display("FAIL reset_q cycle %0d: got %b want 0", i, q); end
            checks++;
            if (y !== 1'b1) begin errors++; $display("FAIL reset_y cycle %0d: got %b want 1", i, y); end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (q !== 1'b0) begin errors++; $display("FAIL reset_release_q: got %b want 0", q); end
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL reset_release_y: got %b want 1", y); end
    endtask

    task automatic test_set_carry();
        a = 1'b1; b = 1'b1;
        #1;
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL set_y_same_cycle: got %b want 0", y); end
        checks++;
        if (q !== 1'b0) begin errors++; $display("FAIL set_q_before_edge: got %b want 0", q); end
        tick();
        checks++;
        if (q !== 1'b1) begin errors++; $display("FAIL set_q_after_edge: got %b want 1", q); end
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL set_y_hold: got %b want 1", y); end
        tick();
        checks++;
        if (q !== 1'b1) begin errors++; $display("FAIL set_q_hold: got %b want 1", q); end
    endtask

    task automatic test_clear_carry();
        a = 1'b0; b = 1'b0;
        #1;
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL clear_y_same_cycle: got %b want 1", y); end
        tick();
        checks++;
        if (q !== 1'b0) begin errors++; $display("FAIL clear_q_after_edge: got %b want 0", q); end
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL clear_y_after_edge: got %b want 0", y); end
        a = 1'b1; b = 1'b0;
        #1;
        checks++;
        if (y !== 1'b1) begin errors++; $display("FAIL clear_y_10: got %b want 1", y); end
        tick();
        checks++;
        if (q !== 1'b0) begin errors++; $display("FAIL clear_q_stays: got %b want 0", q); end
    endtask

    task automatic test_add_5_3();
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] yv;
        logic [3:0] qv;
        av = 4'b0101;   // 5, LSB first: 1,0,1,0
        bv = 4'b0011;   // 3, LSB first: 1,1,0,0
        yv = 4'b1000;   // 8
        qv = 4'b0111;   // carry after edges: 1,1,1,0
        reset = 1'b0; a = 1'b0; b = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = av[i]; b = bv[i];
            #1;
            checks++;
            if (y !== yv[i]) begin errors++; $display("FAIL add53_y bit %0d: got %b want %b", i, y, yv[i]); end
            tick();
            checks++;
            if (q !== qv[i]) begin errors++; $display("FAIL add53_q bit %0d: got %b want %b", i, q, qv[i]); end
        end
    endtask

    task automatic test_reset_wins();
        reset = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        checks++;
        if (q !== 1'b1) begin errors++; $display("FAIL rw_reach_carry1: got %b want 1", q); end
        reset = 1'b0;
        tick();
        checks++;
        if (q !== 1'b0) begin errors++; $display("FAIL rw_q: got %b want 0", q); end
        checks++;
        if (y !== 1'b0) begin errors++; $display("FAIL rw_y: got %b want 0", y); end
        reset = 1'b1;
    endtask

    task automatic test_exhaustive();
        logic ea;
        logic eb;
        logic eq;
        logic exp_y;
        logic exp_q;
        for (int s = 0; s < 8; s++) begin
            eq = s[2]; ea = s[1]; eb = s[0];
            reset = 1'b0; a = 1'b0; b = 1'b0;
            tick();
            reset = 1'b1;
            if (eq == 1'b1) begin
                a = 1'b1; b = 1'b1;
                tick();
            end
            exp_y = ea ^ eb ^ eq;
            exp_q = (ea & eb) | (ea & eq) | (eb & eq);
            a = ea; b = eb;
            #1;
            checks++;
            if (q !== eq) begin errors++; $display("FAIL exh_start_q abq=%b%b%b: got %b want %b", ea, eb, eq, q, eq); end
            checks++;
            if (y !== exp_y) begin errors++; $display("FAIL exh_y abq=%b%b%b: got %b want %b", ea, eb, eq, y, exp_y); end
            tick();
            checks++;
            if (q !== exp_q) begin errors++; $display("FAIL exh_next_q abq=%b%b%b: got %b want %b", ea, eb, eq, q, exp_q); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b0; a = 1'b0; b = 1'b0;
        test_reset();
        test_set_carry();
        test_clear_carry();
        test_add_5_3();
        test_reset_wins();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_mealy.md
SERIAL_ADDER_MEALY -- requirements
Module: serial_adder_mealy

Interface
REQ-001 Parameter CARRY_INIT, default 1'b0: carry state loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous active-low reset, sampled only on clk rising edge.
REQ-004 a  input  1  serial operand A bit, LSB first, one bit per clk cycle.
REQ-005 b  input  1  serial operand B bit, LSB first, one bit per clk cycle.
REQ-006 y  output  1  serial sum bit for the current cycle (Mealy, combinational from a, b, state).
REQ-007 q  output  1  current carry state (registered), i.e. carry-in to the present bit.

Function
REQ-008 The block SHALL be a two-state Mealy FSM: CARRY0 (q=0) and CARRY1 (q=1).
REQ-009 y SHALL equal a XOR b XOR q at all times, zero-cycle latency from a/b changes.
REQ-010 Next carry SHALL be majority(a, b, q) = (a&b) | (a&q) | (b&q).
REQ-011 Transitions: CARRY0 -> CARRY1 only when a=b=1; CARRY1 -> CARRY0 only when a=b=0; otherwise state holds.
REQ-012 q SHALL change only at a clk rising edge; never combinationally.
REQ-013 One serial bit SHALL be consumed per cycle with no enable, handshake, or word-length limit; the operation is unbounded and wraps nothing.
REQ-014 The final carry-out of an N-bit addition SHALL be visible on q in the cycle after the MSB is presented.
REQ-015 Simultaneous reset and a=b=1: reset SHALL win; q becomes CARRY_INIT.
REQ-016 y and q SHALL be free of X once one reset edge has occurred and a, b are known.

Reset
REQ-017 When reset=0 at a clk rising edge, the state SHALL load CARRY_INIT (default 0 -> CARRY0), irrespective of a and b.
REQ-018 While reset is held low, q SHALL stay at CARRY_INIT, and y SHALL still follow REQ-009 (a XOR b for default).
REQ-019 Reset asserted mid-operation SHALL discard the pending carry on the next edge; no other state exists.
REQ-020 Before the first reset edge, q is undefined; the bench SHALL not check outputs then.

Structure
REQ-021 A shared package SHALL hold the state encoding constants CARRY0=1'b0, CARRY1=1'b1 and the state type.
REQ-022 One sub-module, full_adder (inputs a, b, cin; outputs sum, cout), SHALL compute y and next carry; serial_adder_mealy holds only the state register and the next-state/reset logic.
REQ-023 The state register SHALL be a single flip-flop; q is driven directly from it.

Verification
REQ-024 Reset low 3 cycles with a=1,b=0 -> q=0, y=1 throughout; release reset -> q remains 0.
REQ-025 From CARRY0, a=b=1 -> y=0 same cycle; after edge q=1; hold a=b=1 -> y=1, q stays 1.
REQ-026 From CARRY1, a=b=0 -> y=1; after edge q=0; then a=1,b=0 -> y=1, q stays 0.
REQ-027 5+3 LSB-first (a=1,0,1,0; b=1,1,0,0) from reset -> y=0,0,0,1 (sum 8), q after each edge = 1,1,1,0.
REQ-028 Reach CARRY1, then drive reset=0 together with a=b=1 for one edge -> q=0, y=a^b=0 after that edge.
REQ-029 Exhaustive: all 8 (a,b,q) combinations -> y and next q match REQ-009/REQ-010.
